// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard/forwarding control.
package mips_ctrl_pkg;

    // Default widths: register address and stall-counter width.
    localparam int REG_AW_DEF   = 5;
    localparam int CNT_W_DEF    = 16;

    // Shadow pipeline depth: EX, MEM, WB, PWB.
    localparam int SHADOW_DEPTH = 4;
    localparam int SH_EX        = 0;
    localparam int SH_MEM       = 1;
    localparam int SH_WB        = 2;

    // EX-stage operand mux selects.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_WB    = 2'b11;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FREEZE     = 2'd2
    } hz_state_t;

    // One in-flight instruction as seen by the hazard unit.
    typedef struct packed {
        logic [REG_AW_DEF-1:0] dest;
        logic                  wr;
        logic                  load;
    } shadow_entry_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// Priority compare of one ID source register against the EX/MEM/WB shadow
// entries; the youngest matching producer wins.
module fwd_sel_calc
    import mips_ctrl_pkg::*;
(
    input  logic [REG_AW_DEF-1:0] src_i,
    input  logic                  uses_i,
    input  shadow_entry_t         ex_i,
    input  shadow_entry_t         mem_i,
    input  shadow_entry_t         wb_i,
    output logic [1:0]            sel_o
);

    // Youngest-first match; $0 never matches because its entries carry wr=0.
    always_comb begin
        sel_o = FWD_RF;
        if (uses_i) begin
            if (ex_i.wr && (ex_i.dest == src_i)) begin
                sel_o = FWD_EXMEM;
            end else if (mem_i.wr && (mem_i.dest == src_i)) begin
                sel_o = FWD_MEMWB;
            end else if (wb_i.wr && (wb_i.dest == src_i)) begin
                sel_o = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage MIPS core: shadow pipeline
// of destination registers, registered forwarding selects, load-use stall,
// branch flush and data-memory freeze control.
module hazard_fwd_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_branch_taken,
    input  logic              mem_wait,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              ifid_flush,
    output logic [CNT_W-1:0]  stall_cycles
);

    // The shadow entry struct is sized from the package default.
    if (REG_AW != REG_AW_DEF) begin : g_aw_check
        $error("hazard_fwd_ctrl: REG_AW must equal mips_ctrl_pkg::REG_AW_DEF");
    end

    shadow_entry_t    shadow_q [SHADOW_DEPTH];
    shadow_entry_t    id_entry;
    hz_state_t        state_q, state_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [1:0]       sel_a, sel_b;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use, id_bubble, stall_inc;

    assign load_use = id_valid && shadow_q[SH_EX].load && shadow_q[SH_EX].wr &&
                      ((id_uses_rs && (id_rs == shadow_q[SH_EX].dest)) ||
                       (id_uses_rt && (id_rt == shadow_q[SH_EX].dest)));

    // A flush or a load-use stall turns the ID instruction into a bubble.
    assign id_bubble = !id_valid || ex_branch_taken || load_use;

    // Build the entry that moves into EX; writes to $0 are never tracked.
    always_comb begin
        id_entry      = '0;
        if (!id_bubble) begin
            id_entry.dest = id_dest;
            id_entry.wr   = id_reg_write && (id_dest != '0);
            id_entry.load = id_mem_read;
        end
    end

    fwd_sel_calc u_fwd_a (
        .src_i  (id_rs),
        .uses_i (id_uses_rs),
        .ex_i   (shadow_q[SH_EX]),
        .mem_i  (shadow_q[SH_MEM]),
        .wb_i   (shadow_q[SH_WB]),
        .sel_o  (sel_a)
    );

    fwd_sel_calc u_fwd_b (
        .src_i  (id_rt),
        .uses_i (id_uses_rt),
        .ex_i   (shadow_q[SH_EX]),
        .mem_i  (shadow_q[SH_MEM]),
        .wb_i   (shadow_q[SH_WB]),
        .sel_o  (sel_b)
    );

    assign fwd_a_d   = id_bubble ? FWD_RF : sel_a;
    assign fwd_b_d   = id_bubble ? FWD_RF : sel_b;
    assign stall_inc = mem_wait || (load_use && !ex_branch_taken);
    assign cnt_d     = (stall_inc && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

    // Next-state logic for the stall/freeze tracker.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN: begin
                if (mem_wait)                              state_d = FREEZE;
                else if (load_use && !ex_branch_taken)     state_d = LOAD_STALL;
            end
            LOAD_STALL: state_d = mem_wait ? FREEZE : RUN;
            FREEZE:     state_d = mem_wait ? FREEZE : RUN;
            default:    state_d = RUN;
        endcase
    end

    // Pipeline enables by priority: reset, freeze, branch flush, load-use, run.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (mem_wait) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
        end else if (ex_branch_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Shadow pipeline, selects and state advance together; a freeze holds all.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SHADOW_DEPTH; i++) shadow_q[i] <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!mem_wait) begin
                shadow_q[0] <= id_entry;
                for (int i = 1; i < SHADOW_DEPTH; i++) shadow_q[i] <= shadow_q[i-1];
                fwd_a_q <= fwd_a_d;
                fwd_b_q <= fwd_b_d;
            end
        end
    end

    assign fwd_a_sel    = fwd_a_q;
    assign fwd_b_sel    = fwd_b_q;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed testbench for hazard_fwd_ctrl with hand-computed expectations.
module tb_hazard_fwd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic        ex_branch_taken, mem_wait;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        pc_write, ifid_write, idex_bubble, ifid_flush;
    logic [15:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_dest         (id_dest),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .idex_bubble     (idex_bubble),
        .ifid_flush      (ifid_flush),
        .stall_cycles    (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic [4:0] dest,
                          input logic rw, input logic mr);
        id_valid     = v;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_dest      = dest;
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        idle();
        repeat (4) tick();
    endtask

    // {pc_write, ifid_write, idex_bubble, ifid_flush}
    function automatic logic [3:0] enables();
        return {pc_write, ifid_write, idex_bubble, ifid_flush};
    endfunction

    initial begin
        reset = 1'b1;
        ex_branch_taken = 1'b0;
        mem_wait = 1'b0;
        idle();
        #2;
        check("reset_enables", enables(), 4'b0011);
        tick();
        tick();
        reset = 1'b0;
        check("reset_fwd_a", fwd_a_sel, 2'b00);
        check("reset_fwd_b", fwd_b_sel, 2'b00);
        check("reset_stall_cnt", stall_cycles, 16'd0);

        // add $3<-$1,$2 ; add $4<-$3,$5
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        #1 check("run_enables", enables(), 4'b1100);
        tick();
        set_id(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0);
        #1 check("raw_no_stall", enables(), 4'b1100);
        tick();
        idle();
        check("exmem_fwd_a", fwd_a_sel, 2'b01);
        check("exmem_fwd_b", fwd_b_sel, 2'b00);
        drain();

        // producer reaches WB before the reader enters EX -> 11
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        tick();
        idle();
        tick();
        tick();
        set_id(1, 5'd7, 5'd3, 1, 1, 5'd9, 1, 0);
        tick();
        idle();
        check("wb_fwd_a", fwd_a_sel, 2'b00);
        check("wb_fwd_b", fwd_b_sel, 2'b11);
        drain();

        // two writers of $3: youngest wins; unused rt ignored
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        tick();
        set_id(1, 5'd3, 5'd4, 1, 1, 5'd3, 1, 0);
        tick();
        check("chain_fwd_a", fwd_a_sel, 2'b01);
        set_id(1, 5'd3, 5'd3, 1, 0, 5'd5, 1, 0);
        tick();
        idle();
        check("youngest_fwd_a", fwd_a_sel, 2'b01);
        check("unused_rt_fwd_b", fwd_b_sel, 2'b00);
        drain();

        // lw $3 ; add $6<-$3,$2 -> one stall cycle, then MEM/WB forward
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1);
        tick();
        set_id(1, 5'd3, 5'd2, 1, 1, 5'd6, 1, 0);
        #1 check("loaduse_enables", enables(), 4'b0010);
        check("loaduse_cnt_before", stall_cycles, 16'd0);
        tick();
        check("loaduse_cnt_after", stall_cycles, 16'd1);
        check("loaduse_released", enables(), 4'b1100);
        check("loaduse_bubble_sel", fwd_a_sel, 2'b00);
        tick();
        idle();
        check("loaduse_fwd_a", fwd_a_sel, 2'b10);
        check("loaduse_fwd_b", fwd_b_sel, 2'b00);
        drain();

        // writer to $0 then reader of $0; also load to $0 then user of $0
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0);
        tick();
        idle();
        check("zero_fwd_a", fwd_a_sel, 2'b00);
        check("zero_fwd_b", fwd_b_sel, 2'b00);
        drain();
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1);
        tick();
        set_id(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0);
        #1 check("zero_load_no_stall", enables(), 4'b1100);
        check("zero_load_cnt", stall_cycles, 16'd1);
        drain();

        // load-use coincident with a taken branch: flush wins
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1);
        tick();
        set_id(1, 5'd3, 5'd2, 1, 1, 5'd6, 1, 0);
        ex_branch_taken = 1'b1;
        #1 check("branch_pc_bub_flush", {pc_write, idex_bubble, ifid_flush}, 3'b111);
        tick();
        ex_branch_taken = 1'b0;
        idle();
        check("branch_cnt", stall_cycles, 16'd1);
        check("branch_flushed_sel", fwd_a_sel, 2'b00);
        drain();

        // freeze for 3 cycles during a forwarded sequence
        set_id(1, 5'd1, 5'd2, 1, 1, 5'd3, 1, 0);
        tick();
        set_id(1, 5'd3, 5'd5, 1, 1, 5'd4, 1, 0);
        tick();
        set_id(1, 5'd4, 5'd3, 1, 1, 5'd8, 1, 0);
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 check("freeze_enables", enables(), 4'b0000);
            tick();
            check("freeze_hold_a", fwd_a_sel, 2'b01);
            check("freeze_hold_b", fwd_b_sel, 2'b00);
        end
        check("freeze_cnt", stall_cycles, 16'd4);
        mem_wait = 1'b0;
        #1 check("freeze_resume", enables(), 4'b1100);
        tick();
        idle();
        check("resume_fwd_a", fwd_a_sel, 2'b01);
        check("resume_fwd_b", fwd_b_sel, 2'b10);
        drain();

        // reset during LOAD_STALL clears everything
        set_id(1, 5'd1, 5'd0, 1, 0, 5'd3, 1, 1);
        tick();
        set_id(1, 5'd3, 5'd3, 1, 1, 5'd9, 1, 0);
        tick();
        check("pre_reset_cnt", stall_cycles, 16'd5);
        reset = 1'b1;
        #1 check("midstall_reset_enables", enables(), 4'b0011);
        tick();
        reset = 1'b0;
        check("postreset_cnt", stall_cycles, 16'd0);
        check("postreset_fwd_a", fwd_a_sel, 2'b00);
        #1 check("postreset_no_stall", enables(), 4'b1100);
        tick();
        idle();
        check("postreset_dep_a", fwd_a_sel, 2'b00);
        check("postreset_dep_b", fwd_b_sel, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
